masked_muxn_gadget: RTL and testbench

MASKED_MUXN_GADGET -- requirements
Module: masked_muxn_gadget

---
 rtl/masked_muxn_gadget.sv | 147 ++++++++++++++
 tb/tb_masked_muxn_gadget.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_muxn_gadget.sv
// Masked N:1 word multiplexer built from a binary tree of HPC2-based two-input masked muxes.
// Every value stays d-share Boolean masked. Each tree stage costs two cycles.
module masked_muxn_gadget #(
    parameter int unsigned d    = 2,
    parameter int unsigned word = 13,
    parameter int unsigned N    = 4,
    localparam int unsigned SEL = $clog2(N),
    localparam int unsigned NR  = (N - 1) * word * d * (d - 1) / 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [N*d*word-1:0]   in_data,
    input  logic [SEL*d-1:0]      in_sel,
    input  logic [NR-1:0]         rnd,
    output logic [d*word-1:0]     out_data,
    output logic                  out_valid,
    output logic                  out_busy
);

    localparam int unsigned DW = d * word;
    localparam int unsigned R  = d * (d - 1) / 2;
    localparam int unsigned L  = 2 * SEL;

    // Offset of the random bit shared by the unordered share pair (i, j), i < j.
    function automatic int unsigned pidx(input int unsigned i, input int unsigned j);
        return i * d - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    // Tree nodes: leaves first, then each stage's outputs; the last node is the root.
    logic [DW-1:0] node [2*N-1];

    for (genvar i = 0; i < N; i++) begin : g_leaf
        assign node[i] = in_data[i*DW +: DW];
    end

    for (genvar s = 0; s < SEL; s++) begin : g_stage
        localparam int unsigned M     = N >> (s + 1);
        localparam int unsigned IOFF  = 2 * N - ((2 * N) >> s);
        localparam int unsigned OOFF  = 2 * N - ((2 * N) >> (s + 1));
        localparam int unsigned RBASE = (N - (N >> s)) * word * R;

        // sc_q[2s] carries select bit s delayed 2s+1 cycles, matching this stage's x_q.
        logic [d-1:0] sc_q [2*s+1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned k = 0; k < 2 * s + 1; k++) sc_q[k] <= '0;
            end else begin
                sc_q[0] <= in_sel[s*d +: d];
                for (int unsigned k = 1; k < 2 * s + 1; k++) sc_q[k] <= sc_q[k-1];
            end
        end

        for (genvar m = 0; m < M; m++) begin : g_mux
            logic [DW-1:0] lo, hi;
            logic [DW-1:0] x_q, lo1_q, lo2_q;
            logic [DW-1:0] and_o;

            assign lo = node[IOFF + 2*m];
            assign hi = node[IOFF + 2*m + 1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    x_q   <= '0;
                    lo1_q <= '0;
                    lo2_q <= '0;
                end else begin
                    x_q   <= hi ^ lo;
                    lo1_q <= lo;
                    lo2_q <= lo1_q;
                end
            end

            for (genvar b = 0; b < word; b++) begin : g_hpc2
                localparam int unsigned RB = RBASE + (m * word + b) * R;

                logic [d-1:0] a_q;
                logic [d-1:0] na_d [d];
                logic [d-1:0] na_q [d];
                logic [d-1:0] bm_d [d];
                logic [d-1:0] bm_q [d];
                logic [d-1:0] c;
                logic         r;

                // Diagonal terms: na is zero and bm holds the plain b_i share.
                always_comb begin
                    r = 1'b0;
                    for (int unsigned i = 0; i < d; i++) begin
                        na_d[i] = '0;
                        bm_d[i] = '0;
                    end
                    for (int unsigned i = 0; i < d; i++) begin
                        for (int unsigned j = 0; j < d; j++) begin
                            if (i == j) begin
                                bm_d[i][j] = x_q[b*d + j];
                            end else begin
                                r = (i < j) ? rnd[RB + pidx(i, j)] : rnd[RB + pidx(j, i)];
                                na_d[i][j] = ~sc_q[2*s][i] & r;
                                bm_d[i][j] = x_q[b*d + j] ^ r;
                            end
                        end
                    end
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_q <= '0;
                        for (int unsigned i = 0; i < d; i++) begin
                            na_q[i] <= '0;
                            bm_q[i] <= '0;
                        end
                    end else begin
                        a_q  <= sc_q[2*s];
                        na_q <= na_d;
                        bm_q <= bm_d;
                    end
                end

                always_comb begin
                    c = '0;
                    for (int unsigned i = 0; i < d; i++) begin
                        for (int unsigned j = 0; j < d; j++) begin
                            c[i] = c[i] ^ na_q[i][j] ^ (a_q[i] & bm_q[i][j]);
                        end
                    end
                end

                assign and_o[b*d +: d] = c;
            end

            assign node[OOFF + m] = and_o ^ lo2_q;
        end
    end

    logic [L-1:0] v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) v_q <= '0;
        else        v_q <= {v_q[L-2:0], in_valid};
    end

    assign out_data  = node[2*N-2];
    assign out_valid = v_q[L-1];
    assign out_busy  = |v_q;

endmodule

// File: tb/tb_masked_muxn_gadget.sv
// Bench for masked_muxn_gadget: an N=4/d=2 and an N=8/d=3 instance checked against an unmasked
// scoreboard of (due cycle, expected word) entries.
module tb_masked_muxn_gadget;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          in_valid4, out_valid4, out_busy4;
    logic [103:0]  in_data4;
    logic [3:0]    in_sel4;
    logic [38:0]   rnd4;
    logic [25:0]   out_data4;

    logic          in_valid8, out_valid8, out_busy8;
    logic [311:0]  in_data8;
    logic [8:0]    in_sel8;
    logic [272:0]  rnd8;
    logic [38:0]   out_data8;

    masked_muxn_gadget #(.d(2), .word(13), .N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_data(in_data4), .in_sel(in_sel4),
        .rnd(rnd4), .out_data(out_data4), .out_valid(out_valid4), .out_busy(out_busy4)
    );

    masked_muxn_gadget #(.d(3), .word(13), .N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_data(in_data8), .in_sel(in_sel8),
        .rnd(rnd8), .out_data(out_data8), .out_valid(out_valid8), .out_busy(out_busy8)
    );

    typedef struct {
        int unsigned due;
        logic [12:0] val;
    } exp_t;

    typedef struct {
        logic [12:0] d [4];
        int unsigned sel;
        logic [12:0] exp;
    } vec_t;

    exp_t q4[$], q8[$];
    int unsigned n_cmp = 0, n_bad = 0;

    logic        nv4, nv8;
    logic [12:0] nd4 [4];
    logic [12:0] nd8 [8];
    int unsigned ns4, ns8;
    logic [12:0] nexp4, nexp8;

    function automatic logic [38:0] mask(input logic [12:0] v, input int unsigned nb, input int unsigned dd);
        logic [38:0] r;
        logic acc, s;
        r = '0;
        for (int unsigned b = 0; b < nb; b++) begin
            acc = v[b];
            for (int unsigned k = 1; k < dd; k++) begin
                s = 1'($urandom_range(0, 1));
                r[b*dd + k] = s;
                acc = acc ^ s;
            end
            r[b*dd] = acc;
        end
        return r;
    endfunction

    function automatic logic [12:0] unmask(input logic [38:0] x, input int unsigned nb, input int unsigned dd);
        logic [12:0] r;
        logic acc;
        r = '0;
        for (int unsigned b = 0; b < nb; b++) begin
            acc = 1'b0;
            for (int unsigned k = 0; k < dd; k++) acc = acc ^ x[b*dd + k];
            r[b] = acc;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [38:0] act, input logic [38:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_outputs();
        logic ev;
        ev = (q4.size() > 0) && (q4[0].due == cyc);
        chk("valid4", 39'(out_valid4), 39'(ev));
        chk("busy4", 39'(out_busy4), 39'(q4.size() > 0));
        if (ev) begin
            chk("data4", 39'(unmask(39'(out_data4), 13, 2)), 39'(q4[0].val));
            void'(q4.pop_front());
        end
        ev = (q8.size() > 0) && (q8[0].due == cyc);
        chk("valid8", 39'(out_valid8), 39'(ev));
        chk("busy8", 39'(out_busy8), 39'(q8.size() > 0));
        if (ev) begin
            chk("data8", 39'(unmask(out_data8, 13, 3)), 39'(q8[0].val));
            void'(q8.pop_front());
        end
    endtask

    task automatic drive();
        logic [38:0] t;
        in_valid4 = nv4;
        for (int unsigned i = 0; i < 4; i++) begin
            t = mask(nd4[i], 13, 2);
            in_data4[i*26 +: 26] = t[25:0];
        end
        t = mask(13'(ns4), 2, 2);
        in_sel4 = t[3:0];
        for (int unsigned i = 0; i < 39; i++) rnd4[i] = 1'($urandom_range(0, 1));
        if (nv4) q4.push_back('{due: cyc + 4, val: nexp4});

        in_valid8 = nv8;
        for (int unsigned i = 0; i < 8; i++) begin
            t = mask(nd8[i], 13, 3);
            in_data8[i*39 +: 39] = t;
        end
        t = mask(13'(ns8), 3, 3);
        in_sel8 = t[8:0];
        for (int unsigned i = 0; i < 273; i++) rnd8[i] = 1'($urandom_range(0, 1));
        if (nv8) q8.push_back('{due: cyc + 6, val: nexp8});
    endtask

    // One clock cycle: check what the DUTs show now, then present the next stimulus.
    task automatic step();
        @(negedge clk);
        check_outputs();
        drive();
    endtask

    task automatic rand4(input logic v);
        nv4 = v;
        for (int unsigned i = 0; i < 4; i++) nd4[i] = 13'($urandom);
        ns4 = $urandom_range(0, 3);
        nexp4 = nd4[ns4];
    endtask

    task automatic rand8(input logic v);
        nv8 = v;
        for (int unsigned i = 0; i < 8; i++) nd8[i] = 13'($urandom);
        ns8 = $urandom_range(0, 7);
        nexp8 = nd8[ns8];
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            rand4(1'b0);
            rand8(1'b0);
            step();
        end
    endtask

    vec_t tbl [5];
    int unsigned accepted;

    initial begin
        tbl[0] = '{d: '{13'h0001, 13'h0AAA, 13'h1555, 13'h1FFF}, sel: 2, exp: 13'h1555};
        tbl[1] = '{d: '{13'h0001, 13'h0AAA, 13'h1555, 13'h1FFF}, sel: 0, exp: 13'h0001};
        tbl[2] = '{d: '{13'h0001, 13'h0AAA, 13'h1555, 13'h1FFF}, sel: 1, exp: 13'h0AAA};
        tbl[3] = '{d: '{13'h0001, 13'h0AAA, 13'h1555, 13'h1FFF}, sel: 3, exp: 13'h1FFF};
        tbl[4] = '{d: '{13'h1234, 13'h0F0F, 13'h00FF, 13'h1ABC}, sel: 1, exp: 13'h0F0F};

        rst_n = 1'b0;
        rand4(1'b0);
        rand8(1'b0);
        drive();
        #1;
        chk("reset_valid4", 39'(out_valid4), 39'd0);
        chk("reset_busy4", 39'(out_busy4), 39'd0);
        chk("reset_data4", 39'(out_data4), 39'd0);
        chk("reset_data8", out_data8, 39'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed single transactions from the vector table.
        for (int unsigned t = 0; t < 5; t++) begin
            rand8(1'b0);
            nv4 = 1'b1;
            for (int unsigned i = 0; i < 4; i++) nd4[i] = tbl[t].d[i];
            ns4 = tbl[t].sel;
            nexp4 = tbl[t].exp;
            step();
            idle(5);
        end

        // Sixteen back-to-back transactions, select cycling.
        for (int unsigned k = 0; k < 16; k++) begin
            rand4(1'b1);
            ns4 = k % 4;
            nexp4 = nd4[ns4];
            rand8(1'b0);
            step();
        end
        idle(6);

        // Alternating valid / bubble.
        for (int unsigned k = 0; k < 4; k++) begin
            rand4(k % 2 == 0);
            rand8(1'b0);
            step();
        end
        idle(6);

        // Reset while three transactions are in flight.
        for (int unsigned k = 0; k < 3; k++) begin
            rand4(1'b1);
            rand8(1'b1);
            step();
        end
        idle(2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        in_valid4 = 1'b0;
        in_valid8 = 1'b0;
        #1;
        chk("midreset_valid4", 39'(out_valid4), 39'd0);
        chk("midreset_busy4", 39'(out_busy4), 39'd0);
        chk("midreset_data4", 39'(out_data4), 39'd0);
        chk("midreset_busy8", 39'(out_busy8), 39'd0);
        chk("midreset_data8", out_data8, 39'd0);
        q4.delete();
        q8.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(8);

        // Wider tree: every select value with fresh randomness.
        for (int unsigned s = 0; s < 8; s++) begin
            rand4(1'b0);
            rand8(1'b1);
            ns8 = s;
            nexp8 = nd8[s];
            step();
        end
        idle(8);

        // Random traffic on both instances.
        accepted = 0;
        for (int unsigned k = 0; k < 20000 && accepted < 10000; k++) begin
            rand4($urandom_range(0, 3) != 0);
            rand8($urandom_range(0, 1) != 0);
            if (nv4) accepted++;
            step();
        end
        chk("random_count", 39'(accepted), 39'd10000);

        for (int unsigned k = 0; k < 20 && (q4.size() > 0 || q8.size() > 0); k++) idle(1);
        idle(1);
        chk("drain4", 39'(q4.size()), 39'd0);
        chk("drain8", 39'(q8.size()), 39'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
